// File: rtl/mixcol_seq.sv
// Iterative AES MixColumns sequencer: COLS columns per cycle through a
// shared column unit, valid/ready in and out, with final-round bypass.
module mixcol_seq #(
    parameter int COLS = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    localparam logic [1:0] LAST_IDX = 2'(4 - COLS);
    localparam logic [1:0] IDX_STEP = 2'(COLS);

    state_t         state_q, state_d;
    logic [127:0]   work_q, work_d;
    logic           byp_q, byp_d;
    logic [1:0]     col_idx_q, col_idx_d;
    logic [127:0]   work_mix;

    function automatic logic [7:0] xtimes(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] b);
        return xtimes(b) ^ b;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtimes(a0) ^ mul3(a1) ^ a2 ^ a3,
                a0 ^ xtimes(a1) ^ mul3(a2) ^ a3,
                a0 ^ a1 ^ xtimes(a2) ^ mul3(a3),
                mul3(a0) ^ a1 ^ a2 ^ xtimes(a3)};
    endfunction

    // Column c lives at bit offset (3-c)*32, i.e. {~c, 5'b0} for a 2-bit c.
    always_comb begin
        logic [1:0] idx;
        idx      = '0;
        work_mix = work_q;
        for (int k = 0; k < COLS; k++) begin
            idx = col_idx_q + 2'(k);
            work_mix[{~idx, 5'b0} +: 32] = mix_col(work_q[{~idx, 5'b0} +: 32]);
        end
    end

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        byp_d     = byp_q;
        col_idx_d = col_idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    work_d    = in_data;
                    byp_d     = in_bypass;
                    col_idx_d = '0;
                    state_d   = S_BUSY;
                end
            end
            S_BUSY: begin
                if (byp_q) begin
                    state_d = S_DONE;
                end else begin
                    work_d    = work_mix;
                    col_idx_d = col_idx_q + IDX_STEP;
                    if (col_idx_q == LAST_IDX) state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            work_q    <= '0;
            byp_q     <= 1'b0;
            col_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            byp_q     <= byp_d;
            col_idx_q <= col_idx_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign out_data  = work_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mixcol_seq.sv
// Self-checking bench for mixcol_seq: directed vector table, stall,
// reset-in-flight and random back-to-back traffic against a GF(2^8) model.
module tb_mixcol_seq;

    localparam int COLS = 1;
    localparam int NCYC = 4 / COLS;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_bypass;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    int nvec = 0;
    int nerr = 0;

    mixcol_seq #(.COLS(COLS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_bypass (in_bypass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] data;
        logic         byp;
        logic [127:0] exp;
    } vec_t;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] st, input logic byp);
        logic [127:0] r;
        logic [7:0]   a [4];
        r = st;
        if (!byp) begin
            for (int c = 0; c < 4; c++) begin
                for (int k = 0; k < 4; k++) a[k] = st[127 - 32*c - 8*k -: 8];
                for (int k = 0; k < 4; k++)
                    r[127 - 32*c - 8*k -: 8] = gmul(a[k], 8'h02) ^ gmul(a[(k+1)%4], 8'h03)
                                             ^ a[(k+2)%4] ^ a[(k+3)%4];
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 128'(in_ready), 128'd1);
    endtask

    // Sends one state, checks latency and result, then drains it.
    task automatic run_vec(input string name, input logic [127:0] d,
                           input logic b, input logic [127:0] exp);
        int lat;
        @(negedge clk);
        wait_ready();
        in_valid  = 1'b1;
        in_data   = d;
        in_bypass = b;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_data   = {$urandom, $urandom, $urandom, $urandom};
        in_bypass = ~b;
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, 128'(lat), 128'(b ? 1 : NCYC));
        chk({name, "_data"}, out_data, exp);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    localparam logic [127:0] S1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] R1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] S2 = 128'hd4d4d4d5_2d26314c_00000000_00000000;
    localparam logic [127:0] R2 = 128'hd5d5d7d6_4d7ebdf8_00000000_00000000;
    localparam logic [127:0] S3 = 128'h00000000_00000000_d4d4d4d5_2d26314c;
    localparam logic [127:0] R3 = 128'h00000000_00000000_d5d5d7d6_4d7ebdf8;
    localparam logic [127:0] S4 = 128'hffffffff_00000000_5a5a5a5a_80808080;

    vec_t         vt [6];
    logic [127:0] q [$];
    logic [127:0] held, d2;
    int           rcvd;

    initial begin
        vt[0] = '{S1, 1'b0, R1};
        vt[1] = '{S2, 1'b0, R2};
        vt[2] = '{S1, 1'b1, S1};
        vt[3] = '{S3, 1'b0, R3};
        vt[4] = '{S4, 1'b0, S4};
        vt[5] = '{S2, 1'b1, S2};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_bypass = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'd0);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 128'(in_ready), 128'd1);

        for (int i = 0; i < 6; i++)
            run_vec($sformatf("vec%0d", i), vt[i].data, vt[i].byp, vt[i].exp);

        // Output stall: result held, second input refused until after handshake.
        @(negedge clk);
        wait_ready();
        in_valid = 1'b1; in_data = S1; in_bypass = 1'b0;
        @(posedge clk);
        #1;
        d2 = S2;
        in_data = d2;
        repeat (NCYC) @(posedge clk);
        @(negedge clk);
        chk("stall_valid0", 128'(out_valid), 128'd1);
        held = out_data;
        chk("stall_data0", held, R1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("stall_valid%0d", i+1), 128'(out_valid), 128'd1);
            chk($sformatf("stall_data%0d", i+1), out_data, held);
            chk($sformatf("stall_in_ready%0d", i+1), 128'(in_ready), 128'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("post_hs_out_valid", 128'(out_valid), 128'd0);
        chk("post_hs_in_ready", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (NCYC) @(posedge clk);
        @(negedge clk);
        chk("second_valid", 128'(out_valid), 128'd1);
        chk("second_data", out_data, R2);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset while BUSY, two columns into the work.
        @(negedge clk);
        wait_ready();
        in_valid = 1'b1; in_data = S1; in_bypass = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 128'(out_valid), 128'd0);
        chk("midrst_out_data", out_data, 128'd0);
        chk("midrst_busy", 128'(busy), 128'd0);
        chk("midrst_in_ready", 128'(in_ready), 128'd1);
        run_vec("after_rst", S3, 1'b0, R3);

        // Random back-to-back traffic with random gaps on both sides.
        rcvd = 0;
        fork
            begin : producer
                int  sent = 0;
                int  guard = 0;
                bit  acc = 0;
                while (sent < 100 && guard < 20000) begin
                    @(negedge clk);
                    guard++;
                    if (acc) begin
                        in_valid = 1'b0;
                        acc = 0;
                    end
                    if (!in_valid && $urandom_range(0, 3) != 0) begin
                        in_valid  = 1'b1;
                        in_data   = {$urandom, $urandom, $urandom, $urandom};
                        in_bypass = ($urandom_range(0, 4) == 0);
                    end
                    if (in_valid && in_ready) begin
                        q.push_back(ref_mix(in_data, in_bypass));
                        sent++;
                        acc = 1;
                    end
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin : consumer
                int guard = 0;
                while (rcvd < 100 && guard < 20000) begin
                    @(negedge clk);
                    guard++;
                    out_ready = ($urandom_range(0, 2) != 0);
                    if (out_valid && out_ready) begin
                        if (q.size() == 0) begin
                            chk($sformatf("rand%0d_extra", rcvd), out_data, 128'hx);
                        end else begin
                            chk($sformatf("rand%0d", rcvd), out_data, q.pop_front());
                        end
                        rcvd++;
                    end
                end
                @(negedge clk);
                out_ready = 1'b0;
            end
        join
        chk("rand_count", 128'(rcvd), 128'd100);
        chk("rand_leftover", 128'(q.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
